// File: rtl/lif_pkg.sv
// lif_pkg: shared FSM states, LFSR constants, Q0.8 shift and saturation helper for the LIF array.
package lif_pkg;
  typedef enum logic [1:0] {IDLE, RUN, STEP_END, DONE} state_t;
  localparam int LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
  localparam int QSHIFT = 8;
  function automatic logic [31:0] sat_w(input logic [31:0] x, input int w);
    logic [31:0] m;
    m = (32'd1 << w) - 32'd1;
    return x > m ? m : x;
  endfunction
endpackage

// File: rtl/lif_neuron_array_if.sv
// lif_neuron_array_if: control, configuration and result signals of the LIF neuron array.
interface lif_neuron_array_if #(parameter int N_CH = 8, DW = 8, CW = 8);
  localparam int AW = $clog2(N_CH);
  logic start;
  logic abort;
  logic [N_CH*DW-1:0] input_current;
  logic [DW-1:0] threshold;
  logic [7:0] beta;
  logic [7:0] weight;
  logic [7:0] n_steps;
  logic [3:0] refrac;
  logic reset_mode;
  logic [AW-1:0] rd_addr;
  logic busy;
  logic [N_CH-1:0] spike_vec;
  logic spike_vec_valid;
  logic [7:0] step_cnt;
  logic done;
  logic [CW-1:0] rd_count;
  modport master (
    output start, abort, input_current, threshold, beta, weight, n_steps, refrac, reset_mode, rd_addr,
    input busy, spike_vec, spike_vec_valid, step_cnt, done, rd_count
  );
  modport slave (
    input start, abort, input_current, threshold, beta, weight, n_steps, refrac, reset_mode, rd_addr,
    output busy, spike_vec, spike_vec_valid, step_cnt, done, rd_count
  );
endinterface

// File: rtl/lif_lfsr.sv
// lif_lfsr: 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1); rnd exposes the low bits of the advanced value.
module lif_lfsr import lif_pkg::*; #(
  parameter logic [LFSR_W-1:0] SEED = 16'h0001,
  parameter int OW = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic [OW-1:0] rnd
);
  logic [LFSR_W-1:0] q, nxt;
  assign nxt = {q[LFSR_W-2:0], ^(q & LFSR_TAPS)};
  assign rnd = nxt[OW-1:0];
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= SEED;
    else if (en) q <= nxt;
endmodule

// File: rtl/lif_neuron_array.sv
// lif_neuron_array: time-multiplexed leaky integrate-and-fire neurons sharing one update datapath.
module lif_neuron_array import lif_pkg::*; #(
  parameter int N_CH = 8,
  parameter int DW = 8,
  parameter int CW = 8,
  parameter logic [15:0] SEED = 16'h0001
) (
  input logic clk,
  input logic reset,
  lif_neuron_array_if.slave bus
);
  localparam int AW = $clog2(N_CH);
  localparam int SW = DW + 9;
  state_t state, state_nxt;
  logic [AW-1:0] ch_idx;
  logic [DW-1:0] mem [N_CH];
  logic [3:0] refr [N_CH];
  logic [CW-1:0] cnt [N_CH];
  logic [N_CH-1:0] spk_acc, spk_now, spike_vec_q;
  logic [7:0] step_q;
  logic [CW-1:0] rd_q;
  logic [DW-1:0] rnd, cur, thr, v_new, v_post;
  logic [SW-1:0] sum;
  logic run, last, accept, in_spk, fire;
  // The random draw uses the value the LFSR advances to for this channel update.
  lif_lfsr #(.SEED(SEED), .OW(DW)) u_lfsr (.clk(clk), .reset(reset), .en(run), .rnd(rnd));
  assign run = state == RUN && !bus.abort;
  assign last = ch_idx == AW'(N_CH - 1);
  assign accept = state == IDLE && bus.start && !bus.abort;
  assign cur = bus.input_current[ch_idx*DW +: DW];
  assign thr = bus.threshold == '0 ? DW'(1) : bus.threshold;
  assign in_spk = rnd < cur;
  assign sum = SW'(mem[ch_idx]) * SW'(bus.beta) + (in_spk ? SW'(cur) * SW'(bus.weight) : '0);
  assign v_new = DW'(sat_w(32'(sum >> QSHIFT), DW));
  assign fire = refr[ch_idx] == 4'd0 && v_new >= thr;
  assign v_post = !fire ? v_new : bus.reset_mode ? '0 : v_new - thr;
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  assign bus.spike_vec_valid = state == STEP_END;
  assign bus.spike_vec = spike_vec_q;
  assign bus.step_cnt = step_q;
  assign bus.rd_count = rd_q;
  always_comb begin
    spk_now = spk_acc;
    spk_now[ch_idx] = fire;
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = bus.n_steps == 8'd0 ? DONE : RUN;
      RUN: if (last) state_nxt = STEP_END;
      STEP_END: state_nxt = step_q + 8'd1 == bus.n_steps ? DONE : RUN;
      DONE: state_nxt = IDLE;
    endcase
    if (bus.abort) state_nxt = IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      ch_idx <= '0;
      step_q <= '0;
      spike_vec_q <= '0;
      spk_acc <= '0;
      rd_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        mem[i] <= '0;
        refr[i] <= '0;
        cnt[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      rd_q <= cnt[bus.rd_addr];
      if (accept) begin
        ch_idx <= '0;
        step_q <= '0;
        spike_vec_q <= '0;
        spk_acc <= '0;
        for (int i = 0; i < N_CH; i++) begin
          mem[i] <= '0;
          refr[i] <= '0;
          cnt[i] <= '0;
        end
      end else if (run) begin
        ch_idx <= last ? '0 : ch_idx + AW'(1);
        spk_acc <= spk_now;
        if (last) spike_vec_q <= spk_now;
        if (refr[ch_idx] != 4'd0) refr[ch_idx] <= refr[ch_idx] - 4'd1;
        else begin
          mem[ch_idx] <= v_post;
          if (fire) begin
            refr[ch_idx] <= bus.refrac;
            cnt[ch_idx] <= cnt[ch_idx] == '1 ? cnt[ch_idx] : cnt[ch_idx] + CW'(1);
          end
        end
      end else if (state == STEP_END && !bus.abort) step_q <= step_q + 8'd1;
    end
endmodule

// File: doc/lif_neuron_array.md
# lif_neuron_array

Time-multiplexed array of N_CH leaky integrate-and-fire neurons sharing one datapath, with per-channel membrane, refractory and spike-count state held in register arrays. It is the parametrised successor of the single-pixel LIF neuron: width, channel count, leak/weight, threshold, reset mode and refractory period are all configurable. It sits between the pixel buffer, which presents all channel currents at once, and the spike readout/classifier logic.

## Interface
- N_CH, 8: number of neuron channels (≥2).
- DW, 8: input current, membrane and threshold width.
- CW, 8: per-channel spike counter width (saturating).
- SEED, 16'h0001: LFSR reset value (nonzero).
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  one-cycle pulse; begins an evaluation window when idle.
- abort  in  1  terminates the window; wins over every other input.
- input_current  in  N_CH*DW  channel c occupies bits [c*DW +: DW]; must be held stable while busy.
- threshold  in  DW  firing threshold; value 0 is treated as 1.
- beta  in  8  leak factor, Q0.8.
- weight  in  8  input weight, Q0.8.
- n_steps  in  8  time steps per window.
- refrac  in  4  refractory steps after a spike.
- reset_mode  in  1  0 = subtract threshold on spike, 1 = zero membrane.
- rd_addr  in  $clog2(N_CH)  spike-count readout channel select.
- busy  out  1  high from the cycle after an accepted start until done.
- spike_vec  out  N_CH  spikes produced in the last completed step.
- spike_vec_valid  out  1  one-cycle strobe, aligned with spike_vec update.
- step_cnt  out  8  completed steps in the current window.
- done  out  1  one-cycle pulse at window end.
- rd_count  out  CW  registered count of channel rd_addr; 1-cycle read latency.

## Operation
- FSM states: IDLE, RUN, STEP_END, DONE.
- IDLE → RUN on start. Entering RUN clears membrane, refractory counters, spike counts, spike_vec, step_cnt and ch_idx. The LFSR is not cleared.
- IDLE → DONE on start when n_steps == 0.
- RUN processes channel ch_idx each cycle and increments ch_idx. After channel N_CH-1 it moves to STEP_END.
- STEP_END: registers spike_vec, pulses spike_vec_valid and increments step_cnt. If step_cnt+1 == n_steps it goes to DONE, otherwise back to RUN with ch_idx = 0.
- DONE: pulses done, then returns to IDLE. Counts and spike_vec hold until the next start.
- Per-channel update, in order:
  - The LFSR (16-bit, x^16+x^14+x^13+x^11+1) advances once per channel update.
  - in_spk = LFSR[DW-1:0] < I_c.
  - If refr_c > 0: decrement refr_c, leave v unchanged, no spike.
  - Otherwise compute sum = v*beta + (in_spk ? I_c*weight : 0), width DW+9. Then v' = sum >> 8, saturated to 2^DW-1.
  - If v' ≥ threshold: fire. v' becomes v'-threshold (reset_mode 0) or 0 (reset_mode 1). refr_c is loaded with refrac, and count_c increments, saturating at 2^CW-1.
- start while busy is ignored.
- abort in any state returns to IDLE next cycle. done is not asserted, and counts are left as-is but are not valid.
- Input changes while busy are undefined use; the block uses whatever value is present in each channel's cycle.

## Timing
- Reset values: busy=0, spike_vec=0, spike_vec_valid=0, step_cnt=0, done=0, rd_count=0, LFSR=SEED, FSM=IDLE.
- start sampled at edge k puts busy high after edge k.
- Each step takes N_CH+1 cycles. spike_vec_valid is high in the STEP_END cycle.
- done is high exactly n_steps*(N_CH+1)+1 cycles after the start edge.
- With n_steps == 0, done is high the cycle after start.
- rd_count reflects rd_addr sampled one edge earlier, including during busy.
- Reset asserted mid-window returns the block to IDLE immediately and clears all state.

## Structure
- Package lif_pkg holds:
  - the FSM state enum;
  - LFSR tap mask and width;
  - Q0.8 shift constant (8);
  - the saturate-to-width helper function.
- Sub-module lif_lfsr: 16-bit Fibonacci LFSR with advance enable and SEED parameter.
- State arrays (membrane, refractory, count) stay in the top level.

## Test plan
- N_CH=4, all currents 0, n_steps=10: zero spikes, all counts 0, done at cycle 51, ten spike_vec_valid strobes.
- ch0 current=255, beta=0, weight=255, threshold=200, refrac=0: every input spike gives v'=254 and a fire. count0 equals the reference-model LFSR hit count.
- Same setup with refrac=2: after each fire, ch0 neither integrates nor fires for exactly 2 steps.
- CW=4, always-firing channel, n_steps=20: count saturates at 15 with no wrap.
- abort at step 3: back to IDLE next cycle, no done. A following start clears counts to 0.
- start during busy is ignored. n_steps=0 gives done one cycle after start. reset mid-window leaves every output at its reset value.
